// File: rtl/wavelet_frame_ctrl.sv
// Frame sequencer for a db_wavelet core: clears the core, streams one frame of samples from
// RAM into it, and collects its results into a result RAM with timeout and overrun reporting.
module wavelet_frame_ctrl #(
    parameter int unsigned N_LEVEL   = 3,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned FLUSH_CYC = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              overrun,
    output logic [ADDR_W-1:0] sample_addr,
    output logic              sample_rd,
    input  logic [31:0]       sample_data,
    output logic              wav_rst,
    output logic [31:0]       wav_data,
    input  logic              wav_we,
    input  logic [31:0]       wav_out,
    output logic [ADDR_W-1:0] res_addr,
    output logic              res_we,
    output logic [31:0]       res_data,
    output logic [ADDR_W-1:0] res_count
);

    localparam int unsigned EXP = FRAME_LEN >> N_LEVEL;
    localparam int unsigned FCW = $clog2(FLUSH_CYC + 1);
    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] ExpCnt    = ADDR_W'(EXP);
    localparam logic [FCW-1:0]    FlushLast = FCW'(FLUSH_CYC - 1);
    localparam logic [FCW-1:0]    FlushMax  = FCW'(FLUSH_CYC);

    typedef enum logic [2:0] {StIdle, StClr, StFeed, StFlush, StDone} state_e;

    state_e            state_q, state_d;
    logic              clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic [FCW-1:0]    flush_cnt_q, flush_cnt_d;
    logic              timeout_q, timeout_d;
    logic              overrun_q, overrun_d;
    logic              res_we_q, res_we_d;
    logic [ADDR_W-1:0] res_addr_q, res_addr_d;
    logic [31:0]       res_data_q, res_data_d;
    logic [ADDR_W-1:0] res_count_q, res_count_d;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        addr_d      = addr_q;
        rd_d        = (state_q == StFeed);
        flush_cnt_d = flush_cnt_q;
        timeout_d   = timeout_q;
        overrun_d   = overrun_q;
        res_we_d    = 1'b0;
        res_addr_d  = res_addr_q;
        res_data_d  = res_data_q;
        res_count_d = res_count_q;

        // Results are only accepted while the core is actually processing a frame.
        if (wav_we && (state_q == StFeed || state_q == StFlush)) begin
            if (res_count_q < ExpCnt) begin
                res_we_d    = 1'b1;
                res_addr_d  = res_count_q;
                res_data_d  = wav_out;
                res_count_d = res_count_q + 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StClr;
                    clr_cnt_d   = 1'b0;
                    res_count_d = '0;
                    timeout_d   = 1'b0;
                end
            end
            StClr: begin
                clr_cnt_d = 1'b1;
                if (clr_cnt_q) begin
                    state_d = StFeed;
                    addr_d  = '0;
                end
            end
            StFeed: begin
                if (addr_q == LastAddr) begin
                    state_d     = StFlush;
                    addr_d      = '0;
                    flush_cnt_d = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StFlush: begin
                if (res_count_q == ExpCnt) begin
                    state_d = StDone;
                end else if (flush_cnt_q >= FlushLast) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end else if (flush_cnt_q != FlushMax) begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            clr_cnt_q   <= 1'b0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            flush_cnt_q <= '0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            res_we_q    <= 1'b0;
            res_addr_q  <= '0;
            res_data_q  <= '0;
            res_count_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            flush_cnt_q <= flush_cnt_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
            res_we_q    <= res_we_d;
            res_addr_q  <= res_addr_d;
            res_data_q  <= res_data_d;
            res_count_q <= res_count_d;
        end
    end

    // RAM data arrives the cycle after the read; rd_q marks that cycle.
    always_comb begin
        busy        = (state_q != StIdle);
        done        = (state_q == StDone);
        timeout     = timeout_q;
        overrun     = overrun_q;
        sample_addr = addr_q;
        sample_rd   = (state_q == StFeed);
        wav_rst     = RST | (state_q == StClr);
        wav_data    = rd_q ? sample_data : 32'd0;
        res_addr    = res_addr_q;
        res_we      = res_we_q;
        res_data    = res_data_q;
        res_count   = res_count_q;
    end

endmodule
